// File: rtl/mainm_arbiter_pkg.sv
// Shared state/owner encodings and tie-break helper for the main-memory arbiter.
// Round-robin tie-break is selected by defining MAINM_ARB_RR_EN.
package mainm_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_TURN = 2'd2
    } arb_state_e;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    // m1 wins when alone, or in a tie when it is the preferred port
    function automatic logic pick_m1(input logic req0, input logic req1, input logic prefer_m1);
        return req1 && (!req0 || prefer_m1);
    endfunction

endpackage

// File: rtl/mainm_arb_mux.sv
// Combinational request mux and return-path steering for the main-memory arbiter.
// Zero latency; only the owner sees mem_ready/mem_spo, everything is 0 when there is no owner.
module mainm_arb_mux
    import mainm_arbiter_pkg::*;
#(
    parameter int BEAT_W = 8
) (
    input  logic [1:0]        owner_i,
    input  logic              m0_burst_en,
    input  logic [BEAT_W-1:0] m0_burst_length,
    input  logic [31:0]       m0_a,
    input  logic [31:0]       m0_d,
    input  logic              m0_we,
    input  logic              m0_rd,
    input  logic              m1_burst_en,
    input  logic [BEAT_W-1:0] m1_burst_length,
    input  logic [31:0]       m1_a,
    input  logic [31:0]       m1_d,
    input  logic              m1_we,
    input  logic              m1_rd,
    input  logic [31:0]       mem_spo,
    input  logic              mem_ready,
    output logic [31:0]       m0_spo,
    output logic              m0_ready,
    output logic [31:0]       m1_spo,
    output logic              m1_ready,
    output logic              mem_burst_en,
    output logic [BEAT_W-1:0] mem_burst_length,
    output logic [31:0]       mem_a,
    output logic [31:0]       mem_d,
    output logic              mem_we,
    output logic              mem_rd
);

    always_comb begin
        mem_burst_en     = 1'b0;
        mem_burst_length = '0;
        mem_a            = '0;
        mem_d            = '0;
        mem_we           = 1'b0;
        mem_rd           = 1'b0;
        m0_spo           = '0;
        m0_ready         = 1'b0;
        m1_spo           = '0;
        m1_ready         = 1'b0;
        case (owner_i)
            OWN_M0: begin
                mem_burst_en     = m0_burst_en;
                mem_burst_length = m0_burst_length;
                mem_a            = m0_a;
                mem_d            = m0_d;
                mem_we           = m0_we;
                mem_rd           = m0_rd;
                m0_spo           = mem_spo;
                m0_ready         = mem_ready;
            end
            OWN_M1: begin
                mem_burst_en     = m1_burst_en;
                mem_burst_length = m1_burst_length;
                mem_a            = m1_a;
                mem_d            = m1_d;
                mem_we           = m1_we;
                mem_rd           = m1_rd;
                m1_spo           = mem_spo;
                m1_ready         = mem_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mainm_arbiter.sv
// Two-master main-memory arbiter: grants whole transactions, counts ready beats, one TURN cycle between owners.
// Grant 1 cycle after request seen in IDLE; ties fixed-priority m0 unless MAINM_ARB_RR_EN (round-robin).
module mainm_arbiter
    import mainm_arbiter_pkg::*;
#(
    parameter int BEAT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_burst_en,
    input  logic [BEAT_W-1:0] m0_burst_length,
    input  logic [31:0]       m0_a,
    input  logic [31:0]       m0_d,
    input  logic              m0_we,
    input  logic              m0_rd,
    output logic [31:0]       m0_spo,
    output logic              m0_ready,
    input  logic              m1_burst_en,
    input  logic [BEAT_W-1:0] m1_burst_length,
    input  logic [31:0]       m1_a,
    input  logic [31:0]       m1_d,
    input  logic              m1_we,
    input  logic              m1_rd,
    output logic [31:0]       m1_spo,
    output logic              m1_ready,
    output logic              mem_burst_en,
    output logic [BEAT_W-1:0] mem_burst_length,
    output logic [31:0]       mem_a,
    output logic [31:0]       mem_d,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic [31:0]       mem_spo,
    input  logic              mem_ready,
    output logic [1:0]        owner
);

    arb_state_e        state_q;
    logic [1:0]        owner_q;
    logic [BEAT_W-1:0] beats_q;
    logic              req0, req1, grant_m1;
    logic [BEAT_W-1:0] beats_m0, beats_m1;

    assign req0     = m0_we | m0_rd;
    assign req1     = m1_we | m1_rd;
    assign beats_m0 = (m0_burst_en && m0_burst_length != '0) ? m0_burst_length : BEAT_W'(1);
    assign beats_m1 = (m1_burst_en && m1_burst_length != '0) ? m1_burst_length : BEAT_W'(1);

`ifdef MAINM_ARB_RR_EN
    logic last_q;   // 1: m1 owned the port last
    assign grant_m1 = pick_m1(req0, req1, !last_q);
`else
    assign grant_m1 = pick_m1(req0, req1, 1'b0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            beats_q <= '0;
`ifdef MAINM_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        state_q <= ST_BUSY;
                        owner_q <= grant_m1 ? OWN_M1 : OWN_M0;
                        beats_q <= grant_m1 ? beats_m1 : beats_m0;
`ifdef MAINM_ARB_RR_EN
                        last_q  <= grant_m1;
`endif
                    end
                end
                ST_BUSY: begin
                    // mem_we/mem_rd mirror the owner, so their drop is an abort
                    if (!(mem_we || mem_rd) || (mem_ready && beats_q == BEAT_W'(1))) begin
                        state_q <= ST_TURN;
                        owner_q <= OWN_NONE;
                    end else if (mem_ready) begin
                        beats_q <= beats_q - BEAT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    owner_q <= OWN_NONE;
                end
            endcase
        end
    end

    assign owner = owner_q;

    mainm_arb_mux #(.BEAT_W(BEAT_W)) u_mux (
        .owner_i          (owner_q),
        .m0_burst_en      (m0_burst_en),
        .m0_burst_length  (m0_burst_length),
        .m0_a             (m0_a),
        .m0_d             (m0_d),
        .m0_we            (m0_we),
        .m0_rd            (m0_rd),
        .m1_burst_en      (m1_burst_en),
        .m1_burst_length  (m1_burst_length),
        .m1_a             (m1_a),
        .m1_d             (m1_d),
        .m1_we            (m1_we),
        .m1_rd            (m1_rd),
        .mem_spo          (mem_spo),
        .mem_ready        (mem_ready),
        .m0_spo           (m0_spo),
        .m0_ready         (m0_ready),
        .m1_spo           (m1_spo),
        .m1_ready         (m1_ready),
        .mem_burst_en     (mem_burst_en),
        .mem_burst_length (mem_burst_length),
        .mem_a            (mem_a),
        .mem_d            (mem_d),
        .mem_we           (mem_we),
        .mem_rd           (mem_rd)
    );

endmodule

// File: tb/tb_mainm_arbiter.sv
// Directed bench for mainm_arbiter; inputs change just after negedge, outputs checked 1ns later.
// Tie-break expectations follow MAINM_ARB_RR_EN.
module tb_mainm_arbiter;

    localparam int BEAT_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_burst_en, m1_burst_en;
    logic [BEAT_W-1:0] m0_burst_length, m1_burst_length;
    logic [31:0]       m0_a, m0_d, m1_a, m1_d;
    logic              m0_we, m0_rd, m1_we, m1_rd;
    logic [31:0]       m0_spo, m1_spo;
    logic              m0_ready, m1_ready;
    logic              mem_burst_en;
    logic [BEAT_W-1:0] mem_burst_length;
    logic [31:0]       mem_a, mem_d, mem_spo;
    logic              mem_we, mem_rd, mem_ready;
    logic [1:0]        owner;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mainm_arbiter #(.BEAT_W(BEAT_W)) dut (
        .clk(clk), .rst(rst),
        .m0_burst_en(m0_burst_en), .m0_burst_length(m0_burst_length),
        .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd),
        .m0_spo(m0_spo), .m0_ready(m0_ready),
        .m1_burst_en(m1_burst_en), .m1_burst_length(m1_burst_length),
        .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd),
        .m1_spo(m1_spo), .m1_ready(m1_ready),
        .mem_burst_en(mem_burst_en), .mem_burst_length(mem_burst_length),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_spo(mem_spo), .mem_ready(mem_ready),
        .owner(owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic [1:0] tie_exp [4];
    int         cnt0, cnt1;

    initial begin
`ifdef MAINM_ARB_RR_EN
        tie_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        tie_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        rst = 1'b1;
        m0_burst_en = 0; m0_burst_length = 0; m0_a = 0; m0_d = 0; m0_we = 0; m0_rd = 0;
        m1_burst_en = 0; m1_burst_length = 0; m1_a = 0; m1_d = 0; m1_we = 0; m1_rd = 0;
        mem_spo = 32'hAAAA_5555; mem_ready = 1'b0;

        // reset state: return path gated even with live mem_spo
        tick(); tick(); #1;
        check("rst_owner", 32'(owner), 0);
        check("rst_mem_rd", 32'(mem_rd), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_a", mem_a, 0);
        check("rst_m0_spo", m0_spo, 0);
        check("rst_m1_spo", m1_spo, 0);
        tick(); rst = 1'b0;

        // single read on m0, memory answers 3 cycles after grant
        tick(); m0_rd = 1; m0_a = 32'h2000_0010; #1;
        check("t1_idle_owner", 32'(owner), 0);
        check("t1_idle_mem_rd", 32'(mem_rd), 0);
        tick(); #1;
        check("t1_grant_owner", 32'(owner), 1);
        check("t1_mem_rd", 32'(mem_rd), 1);
        check("t1_mem_a", mem_a, 32'h2000_0010);
        tick(); tick(); #1;
        check("t1_wait_ready", 32'(m0_ready), 0);
        tick(); mem_ready = 1; mem_spo = 32'hDEAD_BEEF; #1;
        check("t1_m0_spo", m0_spo, 32'hDEAD_BEEF);
        check("t1_m0_ready", 32'(m0_ready), 1);
        check("t1_m1_spo", m1_spo, 0);
        check("t1_m1_ready", 32'(m1_ready), 0);
        tick(); mem_ready = 0; m0_rd = 0; #1;
        check("t1_turn_owner", 32'(owner), 0);
        check("t1_turn_mem_rd", 32'(mem_rd), 0);
        tick(); #1;
        check("t1_idle2_owner", 32'(owner), 0);

        // burst of 8 on m1; m0 request arrives on the last beat
        m1_rd = 1; m1_burst_en = 1; m1_burst_length = 8; m1_a = 32'h0000_4000;
        tick(); #1;
        check("t2_owner", 32'(owner), 2);
        check("t2_mem_len", 32'(mem_burst_length), 8);
        check("t2_mem_burst_en", 32'(mem_burst_en), 1);
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            mem_ready = 1; mem_spo = 32'h1000 + i;
            if (i == 7) m0_rd = 1;
            #1;
            cnt0 += int'(m0_ready);
            cnt1 += int'(m1_ready);
            if (i == 7) check("t2_owner_beat8", 32'(owner), 2);
        end
        check("t2_m1_beats", cnt1, 8);
        check("t2_m0_beats", cnt0, 0);
        tick(); mem_ready = 0; m1_rd = 0; m1_burst_en = 0; m1_burst_length = 0; #1;
        check("t2_turn_owner", 32'(owner), 0);
        check("t2_turn_mem_rd", 32'(mem_rd), 0);
        tick(); #1;
        check("t2_late_req_idle", 32'(owner), 0);
        tick(); mem_ready = 1; #1;
        check("t2_late_req_grant", 32'(owner), 1);
        tick(); mem_ready = 0; m0_rd = 0; #1;
        check("t2_late_turn", 32'(owner), 0);
        tick();

        // simultaneous requests straight after reset
        rst = 1; tick(); rst = 0; m0_rd = 1; m1_rd = 1;
        for (int k = 0; k < 4; k++) begin
            tick(); mem_ready = 1; #1;
            check($sformatf("t3_tie_owner%0d", k), 32'(owner), 32'(tie_exp[k]));
            tick(); mem_ready = 0;
            if (k == 3) begin m0_rd = 0; m1_rd = 0; end
            #1;
            check($sformatf("t3_turn%0d", k), 32'(owner), 0);
            tick();
        end

        // abort: m0 burst of 4 drops rd after 2 beats, m1 pending
        m0_rd = 1; m0_burst_en = 1; m0_burst_length = 4;
        tick(); m1_rd = 1; mem_ready = 1; #1;
        check("t4_owner", 32'(owner), 1);
        tick(); #1;
        check("t4_beat2_ready", 32'(m0_ready), 1);
        tick(); m0_rd = 0; mem_ready = 0; #1;
        check("t4_drop_mem_rd", 32'(mem_rd), 0);
        check("t4_drop_owner", 32'(owner), 1);
        tick(); #1;
        check("t4_turn_owner", 32'(owner), 0);
        tick(); #1;
        check("t4_idle_owner", 32'(owner), 0);
        tick(); #1;
        check("t4_m1_owner", 32'(owner), 2);
        check("t4_m1_mem_rd", 32'(mem_rd), 1);
        mem_ready = 1;
        tick(); mem_ready = 0; m1_rd = 0; m0_burst_en = 0; m0_burst_length = 0;
        tick();

        // burst_en with length 0 completes after a single beat
        m0_we = 1; m0_burst_en = 1; m0_burst_length = 0; m0_d = 32'h1234_5678;
        tick(); mem_ready = 1; #1;
        check("t5_owner", 32'(owner), 1);
        check("t5_mem_we", 32'(mem_we), 1);
        check("t5_mem_d", mem_d, 32'h1234_5678);
        tick(); mem_ready = 0; #1;
        check("t5_turn_owner", 32'(owner), 0);
        check("t5_turn_mem_we", 32'(mem_we), 0);
        m0_we = 0; m0_burst_en = 0;
        tick();

        // reset during beat 3 of 8
        m0_rd = 1; m0_burst_en = 1; m0_burst_length = 8; m0_a = 32'h0000_8000;
        tick(); mem_ready = 1;
        tick();
        tick(); rst = 1; #1;
        check("t6_beat3_ready", 32'(m0_ready), 1);
        tick(); rst = 0; mem_ready = 0; m0_rd = 0; m0_burst_en = 0; m1_rd = 1; m1_a = 32'h0000_0040; #1;
        check("t6_rst_owner", 32'(owner), 0);
        check("t6_rst_mem_rd", 32'(mem_rd), 0);
        check("t6_rst_mem_burst_en", 32'(mem_burst_en), 0);
        check("t6_rst_mem_a", mem_a, 0);
        tick(); #1;
        check("t6_m1_owner", 32'(owner), 2);
        check("t6_m1_mem_a", mem_a, 32'h0000_0040);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
